bus_rr_arbiter: RTL and testbench
=================================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 The block SHALL have parameter NrHosts, default 2, number of requesting hosts (2..8).
REQ-002 The block SHALL have parameter DataWidth, default 32, data bus width.
REQ-003 The block SHALL have parameter AddressWidth, default 32, address bus width.
REQ-004 The block SHALL have parameter TimeoutCycles, default 16, maximum number of response-wait cycles (2..255).
REQ-005 The block SHALL have port clk_i  in  1  clock; the block uses one clock only.
REQ-006 The block SHALL have port rst_ni  in  1  reset; synchronous, active-low.
REQ-007 The block SHALL have port host_req_i/host_we_i  in  1 [NrHosts]  per-host request and write enable.
REQ-008 The block SHALL have port host_addr_i/host_be_i/host_wdata_i  in  AddressWidth/DataWidth/8/DataWidth [NrHosts]  per-host address, byte enables and write data.
REQ-009 The block SHALL have port host_gnt_o/host_rvalid_o/host_err_o  out  1 [NrHosts]  per-host grant, response valid and error.
REQ-010 The block SHALL have port host_rdata_o  out  DataWidth [NrHosts]  per-host read data.
REQ-011 The block SHALL have port dev_req_o/dev_we_o  out  1  device request and write enable.
REQ-012 The block SHALL have port dev_addr_o/dev_be_o/dev_wdata_o  out  AddressWidth/DataWidth/8/DataWidth  device address, byte enables and write data.
REQ-013 The block SHALL have port dev_gnt_i/dev_rvalid_i/dev_err_i  in  1  device grant, response valid and error.
REQ-014 The block SHALL have port dev_rdata_i  in  DataWidth  device read data.

Function
REQ-015 The block SHALL implement FSM states IDLE, REQ and RESP, and SHALL allow at most one outstanding transaction.
REQ-016 In IDLE, the round-robin picker SHALL select the first requesting host searching upward from (last_owner+1) mod NrHosts; no request SHALL mean stay in IDLE with dev_req_o=0.
REQ-017 In IDLE with a selection, the block SHALL drive dev_req_o=1 and the selected host's we/addr/be/wdata combinationally in the same cycle.
REQ-018 On dev_gnt_i=1 with dev_req_o=1, host_gnt_o[owner] SHALL be 1 in the same cycle; the block SHALL register owner, set last_owner=owner and go to RESP.
REQ-019 If dev_gnt_i=0 while in IDLE with a selection, the block SHALL register owner and go to REQ; the owner SHALL stay locked in REQ, and new or higher-index requests SHALL NOT change it.
REQ-020 In REQ, the block SHALL drive dev_req_o=1 with the locked owner's signals until dev_gnt_i=1, then behave per REQ-018.
REQ-021 If the owner drops host_req_i while in REQ, the block SHALL deassert dev_req_o and return to IDLE without updating last_owner.
REQ-022 In RESP, the block SHALL hold dev_req_o=0 and all host_gnt_o=0, and a 8-bit wait counter SHALL start at 1 on RESP entry and increment each RESP cycle.
REQ-023 In RESP with dev_rvalid_i=1, the block SHALL drive host_rvalid_o[owner]=1 with host_rdata_o[owner]=dev_rdata_i and host_err_o[owner]=dev_err_i in the same cycle, then go to IDLE.
REQ-024 In RESP, when the counter equals TimeoutCycles and dev_rvalid_i=0, the block SHALL drive host_rvalid_o[owner]=1, host_err_o[owner]=1 and host_rdata_o[owner]=0, then go to IDLE.
REQ-025 If dev_rvalid_i and timeout occur in the same cycle, the device response SHALL win.
REQ-026 The block SHALL silently drop dev_rvalid_i seen in IDLE or REQ, whether late after a timeout or spurious.
REQ-027 The block SHALL perform no arbitration in the cycle a response completes; the next grant SHALL be one cycle after the response at the earliest.
REQ-028 Non-owner hosts, and all hosts outside a response cycle, SHALL see host_rvalid_o=0, host_err_o=0 and host_rdata_o=0.
REQ-029 The device outputs SHALL be 0 whenever dev_req_o=0.

Reset
REQ-030 While rst_ni=0 at a clk_i edge, the block SHALL set the FSM to IDLE, owner=0, last_owner=NrHosts-1 (so host 0 wins first) and counter=0.
REQ-031 Reset mid-transaction SHALL abandon the transaction without a host response, and the first cycle after reset SHALL be IDLE.
REQ-032 All outputs SHALL be 0 during reset, except dev_* outputs driven by IDLE combinational selection, which SHALL be gated to 0 while rst_ni=0.

Structure
REQ-033 The package bus_arb_pkg SHALL hold the FSM state enum (arb_state_e) and the default TimeoutCycles constant.
REQ-034 The sub-module rr_pick SHALL be combinational: request vector plus last_owner in, one-hot grant and index out.

Verification
REQ-035 The bench SHALL drive hosts 0 and 1 requesting continuously with dev_gnt_i=1 and 1-cycle rvalid, and SHALL check grants alternate 0,1,0,1, each two cycles after the previous grant.
REQ-036 The bench SHALL hold dev_gnt_i=0 for 3 cycles with host 0 requesting, raise host 1 during the stall, and SHALL check the device sees host 0's addr throughout and host_gnt_o[0] on the 4th cycle.
REQ-037 The bench SHALL send a read with addr 0x100 and dev_rdata_i=0xDEADBEEF after 5 RESP cycles, and SHALL check host_rdata_o[owner]=0xDEADBEEF, err=0, and other hosts' rdata=0.
REQ-038 The bench SHALL test TimeoutCycles=4 with no rvalid, and SHALL check host_rvalid_o=1 and err=1 at the 4th RESP cycle; a late rvalid one cycle later SHALL produce no host response.
REQ-039 The bench SHALL drive rvalid and timeout in the same cycle, and SHALL check err=dev_err_i (0) and rdata=dev_rdata_i.
REQ-040 The bench SHALL assert rst_ni=0 for 1 cycle while in RESP, and SHALL check that all outputs are 0 and that host 0 is granted first after release.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and defaults for the single-outstanding round-robin bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int unsigned DefaultTimeoutCycles = 32'd16;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester searching upward from last_i+1.
module rr_pick #(
    parameter int unsigned N    = 2,
    parameter int unsigned IdxW = 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    // Wrap-around priority search; the first hit locks the index.
    always_comb begin
        int          cand;
        logic        hit;
        logic        found;
        logic [IdxW-1:0] idx;
        cand  = 0;
        hit   = 1'b0;
        found = 1'b0;
        idx   = '0;
        gnt_o = '0;
        for (int k = 1; k <= int'(N); k++) begin
            cand  = (int'(last_i) + k) % int'(N);
            hit   = req_i[cand] & ~found;
            idx   = hit ? IdxW'(cand) : idx;
            found = found | hit;
        end
        gnt_o[idx] = found;
        idx_o      = idx;
        valid_o    = found;
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter sharing one device port among NrHosts hosts,
// one outstanding transaction at a time with a response-wait timeout.
module bus_rr_arbiter
    import bus_arb_pkg::*;
#(
    parameter int unsigned NrHosts       = 2,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned TimeoutCycles = DefaultTimeoutCycles
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NrHosts-1:0]        host_req_i,
    input  logic [NrHosts-1:0]        host_we_i,
    input  logic [AddressWidth-1:0]   host_addr_i  [NrHosts],
    input  logic [DataWidth/8-1:0]    host_be_i    [NrHosts],
    input  logic [DataWidth-1:0]      host_wdata_i [NrHosts],
    output logic [NrHosts-1:0]        host_gnt_o,
    output logic [NrHosts-1:0]        host_rvalid_o,
    output logic [NrHosts-1:0]        host_err_o,
    output logic [DataWidth-1:0]      host_rdata_o [NrHosts],
    output logic                      dev_req_o,
    output logic                      dev_we_o,
    output logic [AddressWidth-1:0]   dev_addr_o,
    output logic [DataWidth/8-1:0]    dev_be_o,
    output logic [DataWidth-1:0]      dev_wdata_o,
    input  logic                      dev_gnt_i,
    input  logic                      dev_rvalid_i,
    input  logic                      dev_err_i,
    input  logic [DataWidth-1:0]      dev_rdata_i
);

    localparam int unsigned     IdxW       = $clog2(NrHosts);
    localparam logic [IdxW-1:0] LastInit   = IdxW'(NrHosts - 32'd1);
    localparam logic [7:0]      TimeoutVal = 8'(TimeoutCycles);

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [NrHosts-1:0] pick_gnt_s;
    logic [IdxW-1:0]    pick_idx_s;
    logic               pick_valid_s;
    logic               dev_sel_s;
    logic               dev_act_s;
    logic [IdxW-1:0]    sel_idx_s;
    logic [NrHosts-1:0] host_gnt_s;
    logic [NrHosts-1:0] host_rvalid_s;
    logic [NrHosts-1:0] host_err_s;
    logic [DataWidth-1:0] host_rdata_s [NrHosts];

    rr_pick #(
        .N    (NrHosts),
        .IdxW (IdxW)
    ) u_pick (
        .req_i   (host_req_i),
        .last_i  (last_q),
        .gnt_o   (pick_gnt_s),
        .idx_o   (pick_idx_s),
        .valid_o (pick_valid_s)
    );

    // Next-state, device selection and per-host response steering.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        dev_sel_s     = 1'b0;
        sel_idx_s     = owner_q;
        host_gnt_s    = '0;
        host_rvalid_s = '0;
        host_err_s    = '0;
        for (int i = 0; i < int'(NrHosts); i++) begin
            host_rdata_s[i] = '0;
        end
        case (state_q)
            IDLE: begin
                if (pick_valid_s) begin
                    dev_sel_s = 1'b1;
                    sel_idx_s = pick_idx_s;
                    owner_d   = pick_idx_s;
                    if (dev_gnt_i) begin
                        host_gnt_s = pick_gnt_s;
                        last_d     = pick_idx_s;
                        cnt_d      = 8'd1;
                        state_d    = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // Owner stays locked until granted or it withdraws.
                if (host_req_i[owner_q]) begin
                    dev_sel_s = 1'b1;
                    if (dev_gnt_i) begin
                        host_gnt_s[owner_q] = 1'b1;
                        last_d  = owner_q;
                        cnt_d   = 8'd1;
                        state_d = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                if (dev_rvalid_i) begin
                    host_rvalid_s[owner_q] = 1'b1;
                    host_err_s[owner_q]    = dev_err_i;
                    host_rdata_s[owner_q]  = dev_rdata_i;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else if (cnt_q == TimeoutVal) begin
                    host_rvalid_s[owner_q] = 1'b1;
                    host_err_s[owner_q]    = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, ownership and wait-counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= LastInit;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Everything is forced low while reset is asserted.
    assign dev_act_s     = dev_sel_s & rst_ni;
    assign dev_req_o     = dev_act_s;
    assign dev_we_o      = dev_act_s & host_we_i[sel_idx_s];
    assign dev_addr_o    = dev_act_s ? host_addr_i[sel_idx_s]  : '0;
    assign dev_be_o      = dev_act_s ? host_be_i[sel_idx_s]    : '0;
    assign dev_wdata_o   = dev_act_s ? host_wdata_i[sel_idx_s] : '0;
    assign host_gnt_o    = rst_ni ? host_gnt_s    : '0;
    assign host_rvalid_o = rst_ni ? host_rvalid_s : '0;
    assign host_err_o    = rst_ni ? host_err_s    : '0;

    for (genvar g = 0; g < int'(NrHosts); g++) begin : g_rdata
        assign host_rdata_o[g] = rst_ni ? host_rdata_s[g] : '0;
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed bench: DUT A uses the default timeout, DUT B a timeout of 4 cycles.
module tb_bus_rr_arbiter;

    localparam int NH = 2;
    localparam int DW = 32;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n;
    logic [NH-1:0]   host_req, host_we;
    logic [AW-1:0]   host_addr  [NH];
    logic [DW/8-1:0] host_be    [NH];
    logic [DW-1:0]   host_wdata [NH];
    logic            dev_gnt, dev_rvalid, dev_err;
    logic [DW-1:0]   dev_rdata;

    logic [NH-1:0]   gnt_a, rvalid_a, err_a, gnt_b, rvalid_b, err_b;
    logic [DW-1:0]   rdata_a [NH];
    logic [DW-1:0]   rdata_b [NH];
    logic            dreq_a, dwe_a, dreq_b, dwe_b;
    logic [AW-1:0]   daddr_a, daddr_b;
    logic [DW/8-1:0] dbe_a, dbe_b;
    logic [DW-1:0]   dwdata_a, dwdata_b;

    int errors = 0;
    int checks = 0;
    logic [1:0] exp_gnt, exp_rv;

    bus_rr_arbiter #(.NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(16)) dut_a (
        .clk_i(clk), .rst_ni(rst_a_n),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_gnt_o(gnt_a), .host_rvalid_o(rvalid_a), .host_err_o(err_a), .host_rdata_o(rdata_a),
        .dev_req_o(dreq_a), .dev_we_o(dwe_a), .dev_addr_o(daddr_a), .dev_be_o(dbe_a),
        .dev_wdata_o(dwdata_a), .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid),
        .dev_err_i(dev_err), .dev_rdata_i(dev_rdata)
    );

    bus_rr_arbiter #(.NrHosts(NH), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(4)) dut_b (
        .clk_i(clk), .rst_ni(rst_b_n),
        .host_req_i(host_req), .host_we_i(host_we), .host_addr_i(host_addr),
        .host_be_i(host_be), .host_wdata_i(host_wdata),
        .host_gnt_o(gnt_b), .host_rvalid_o(rvalid_b), .host_err_o(err_b), .host_rdata_o(rdata_b),
        .dev_req_o(dreq_b), .dev_we_o(dwe_b), .dev_addr_o(daddr_b), .dev_be_o(dbe_b),
        .dev_wdata_o(dwdata_b), .dev_gnt_i(dev_gnt), .dev_rvalid_i(dev_rvalid),
        .dev_err_i(dev_err), .dev_rdata_i(dev_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        host_req = 2'b00;
        host_we  = 2'b10;
        host_addr[0]  = 32'h0000_0100;
        host_addr[1]  = 32'h2000_0040;
        host_be[0]    = 4'hF;
        host_be[1]    = 4'h3;
        host_wdata[0] = 32'h0000_0000;
        host_wdata[1] = 32'hCAFE_0001;
        dev_gnt = 1'b0; dev_rvalid = 1'b0; dev_err = 1'b0; dev_rdata = 32'h0;
        next_cyc();
        next_cyc();

        // Requests present during reset must not leak to any output
        host_req = 2'b11; dev_gnt = 1'b1; dev_rvalid = 1'b1; dev_rdata = 32'h1111_2222;
        smp();
        chk("rst_dev_req", dreq_a, 1'b0);
        chk("rst_dev_addr", daddr_a, 32'h0);
        chk("rst_gnt", gnt_a, 2'b00);
        chk("rst_rvalid", rvalid_a, 2'b00);
        next_cyc();
        rst_a_n = 1'b1;

        // Continuous requests from both hosts: grants alternate every two cycles
        for (int i = 0; i < 8; i++) begin
            smp();
            exp_gnt = (i % 2 != 0) ? 2'b00 : ((i % 4 == 0) ? 2'b01 : 2'b10);
            exp_rv  = (i % 2 == 0) ? 2'b00 : ((i % 4 == 1) ? 2'b01 : 2'b10);
            chk("rr_gnt", gnt_a, exp_gnt);
            chk("rr_rvalid", rvalid_a, exp_rv);
            if (i == 1) begin
                chk("rr_rdata0", rdata_a[0], 32'h1111_2222);
                chk("rr_rdata1", rdata_a[1], 32'h0);
            end
            if (i == 2) begin
                chk("rr_dev_we", dwe_a, 1'b1);
                chk("rr_dev_be", dbe_a, 4'h3);
                chk("rr_dev_wdata", dwdata_a, 32'hCAFE_0001);
            end
            next_cyc();
        end

        // Idle with a spurious response and no requests
        host_req = 2'b00;
        smp();
        chk("idle_dev_req", dreq_a, 1'b0);
        chk("idle_dev_addr", daddr_a, 32'h0);
        chk("spurious_rvalid", rvalid_a, 2'b00);
        chk("spurious_rdata0", rdata_a[0], 32'h0);
        next_cyc();

        // Device stalls three cycles; host 1 joins but host 0 stays locked
        host_req = 2'b01; dev_gnt = 1'b0; dev_rvalid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            if (s == 1) host_req = 2'b11;
            if (s == 3) dev_gnt = 1'b1;
            smp();
            chk("stall_dev_req", dreq_a, 1'b1);
            chk("stall_dev_addr", daddr_a, 32'h0000_0100);
            chk("stall_gnt", gnt_a, (s == 3) ? 2'b01 : 2'b00);
            next_cyc();
        end

        // Read of 0x100 answered after five waiting response cycles
        host_req = 2'b00; dev_gnt = 1'b0; dev_rdata = 32'hDEAD_BEEF;
        for (int w = 0; w < 5; w++) begin
            smp();
            chk("wait_rvalid", rvalid_a, 2'b00);
            chk("wait_dev_req", dreq_a, 1'b0);
            next_cyc();
        end
        dev_rvalid = 1'b1; dev_err = 1'b0;
        smp();
        chk("read_rvalid", rvalid_a, 2'b01);
        chk("read_err", err_a, 2'b00);
        chk("read_rdata0", rdata_a[0], 32'hDEAD_BEEF);
        chk("read_rdata1", rdata_a[1], 32'h0);
        next_cyc();
        dev_rvalid = 1'b0;
        smp();
        chk("after_read_rvalid", rvalid_a, 2'b00);
        next_cyc();

        // Reset while waiting for a response abandons it
        host_req = 2'b01; dev_gnt = 1'b1;
        smp();
        chk("pre_rst_gnt", gnt_a, 2'b01);
        next_cyc();
        rst_a_n = 1'b0; dev_rvalid = 1'b1; dev_rdata = 32'h0000_0055; host_req = 2'b11;
        smp();
        chk("midrst_gnt", gnt_a, 2'b00);
        chk("midrst_rvalid", rvalid_a, 2'b00);
        chk("midrst_err", err_a, 2'b00);
        chk("midrst_rdata0", rdata_a[0], 32'h0);
        chk("midrst_rdata1", rdata_a[1], 32'h0);
        chk("midrst_dev_req", dreq_a, 1'b0);
        chk("midrst_dev_we", dwe_a, 1'b0);
        chk("midrst_dev_addr", daddr_a, 32'h0);
        chk("midrst_dev_be", dbe_a, 4'h0);
        chk("midrst_dev_wdata", dwdata_a, 32'h0);
        next_cyc();
        rst_a_n = 1'b1; dev_rvalid = 1'b0;
        smp();
        chk("postrst_gnt", gnt_a, 2'b01);
        chk("postrst_rvalid", rvalid_a, 2'b00);
        next_cyc();
        host_req = 2'b00; dev_gnt = 1'b0; dev_rvalid = 1'b1; dev_rdata = 32'h0;
        smp();
        chk("postrst_resp", rvalid_a, 2'b01);
        next_cyc();

        // Timeout instance: hold A in reset, release B
        dev_rvalid = 1'b0; rst_a_n = 1'b0; rst_b_n = 1'b1;
        host_req = 2'b01; dev_gnt = 1'b1;
        smp();
        chk("to_gnt", gnt_b, 2'b01);
        next_cyc();
        host_req = 2'b00; dev_gnt = 1'b0; dev_rdata = 32'h1234_5678;
        for (int w = 0; w < 3; w++) begin
            smp();
            chk("to_wait_rvalid", rvalid_b, 2'b00);
            next_cyc();
        end
        smp();
        chk("to_rvalid", rvalid_b, 2'b01);
        chk("to_err", err_b, 2'b01);
        chk("to_rdata0", rdata_b[0], 32'h0);
        next_cyc();
        dev_rvalid = 1'b1;
        smp();
        chk("late_rvalid", rvalid_b, 2'b00);
        chk("late_err", err_b, 2'b00);
        chk("late_rdata0", rdata_b[0], 32'h0);
        next_cyc();

        // Response arrives exactly on the timeout cycle: device wins
        dev_rvalid = 1'b0; host_req = 2'b10; dev_gnt = 1'b1;
        smp();
        chk("race_gnt", gnt_b, 2'b10);
        next_cyc();
        host_req = 2'b00; dev_gnt = 1'b0;
        for (int w = 0; w < 3; w++) begin
            smp();
            chk("race_wait_rvalid", rvalid_b, 2'b00);
            next_cyc();
        end
        dev_rvalid = 1'b1; dev_err = 1'b0; dev_rdata = 32'hA5A5_5A5A;
        smp();
        chk("race_rvalid", rvalid_b, 2'b10);
        chk("race_err", err_b, 2'b00);
        chk("race_rdata1", rdata_b[1], 32'hA5A5_5A5A);
        chk("race_rdata0", rdata_b[0], 32'h0);
        next_cyc();

        // Owner withdraws while stalled: no change to round-robin history
        dev_rvalid = 1'b0; host_req = 2'b01; dev_gnt = 1'b0;
        smp();
        chk("wd_dev_req", dreq_b, 1'b1);
        chk("wd_dev_addr", daddr_b, 32'h0000_0100);
        next_cyc();
        host_req = 2'b00;
        smp();
        chk("wd_drop_req", dreq_b, 1'b0);
        next_cyc();
        host_req = 2'b11; dev_gnt = 1'b1;
        smp();
        chk("wd_next_gnt", gnt_b, 2'b01);
        next_cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
